// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with exception redirect sequencing
// and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_stallreq,
    input  logic             id_stallreq,
    input  logic             ex_stallreq,
    input  logic             mem_stallreq,
    input  logic             exc_flag,
    input  logic [31:0]      exc_target,
    input  logic             ibus_busy,
    input  logic             cnt_clr,
    output logic [4:0]       stall,
    output logic [4:0]       flush,
    output logic             redirect,
    output logic [31:0]      flush_pc,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {RUN, EXC_WAIT, REDIRECT} state_t;
    state_t state, state_nx;
    logic [2:0] k;
    logic draining;
    always_comb begin
        k = mem_stallreq ? 3'd4 : ex_stallreq ? 3'd3 : id_stallreq ? 3'd2 : if_stallreq ? 3'd1 : 3'd0;
        draining = (state == EXC_WAIT) || (state == RUN && exc_flag);
        // Highest requester k freezes everything upstream and bubbles itself.
        stall = rst ? 5'b0 : (state == REDIRECT) ? 5'b0 : draining ? 5'b00001 : 5'((6'd1 << k) - 6'd1);
        flush = rst ? 5'b0 : (state == REDIRECT || draining) ? 5'b11110 : (k == 3'd0) ? 5'b0 : 5'(6'd1 << k);
        state_nx = (state == REDIRECT) ? RUN :
                   (state == EXC_WAIT) ? (ibus_busy ? EXC_WAIT : REDIRECT) :
                   exc_flag ? (ibus_busy ? EXC_WAIT : REDIRECT) : RUN;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            flush_pc  <= 32'h0;
            redirect  <= 1'b0;
            busy      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nx;
            redirect <= (state_nx == REDIRECT);
            busy     <= (state_nx != RUN);
            if (state == RUN && exc_flag)
                flush_pc <= exc_target;
            if (cnt_clr)
                stall_cnt <= '0;
            else if (state == RUN && stall[0] && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the five-stage MangoMIPS32 core. It collects per-stage stall requests and the commit-point exception/ERET request, and produces the per-register `stall` and `flush` vectors consumed by the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It sequences the exception redirect: it drains the pipeline, waits out any outstanding instruction-bus transaction, then issues a single redirect pulse with the latched target PC. It also keeps a stall-cycle performance counter.

## Interface
- CNT_W, 32, width of the stall-cycle counter.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- if_stallreq  in  1  IF stage stall request (I-cache miss).
- id_stallreq  in  1  ID stage stall request (load-use hazard).
- ex_stallreq  in  1  EX stage stall request (mul/div busy).
- mem_stallreq  in  1  MEM stage stall request (D-cache miss).
- exc_flag  in  1  exception or ERET committing in MEM this cycle.
- exc_target  in  32  redirect PC, valid with `exc_flag`.
- ibus_busy  in  1  instruction-bus transaction outstanding.
- cnt_clr  in  1  synchronous clear of `stall_cnt`.
- stall  out  5  bit0 = PC, bit1 = IF/ID, bit2 = ID/EX, bit3 = EX/MEM, bit4 = MEM/WB.
- flush  out  5  same indexing; stage registers give flush priority over stall.
- redirect  out  1  one-cycle pulse: PC loads `flush_pc`.
- flush_pc  out  32  latched redirect target.
- busy  out  1  high when the FSM is in EXC_WAIT or REDIRECT.
- stall_cnt  out  CNT_W  count of cycles with `stall[0]`=1 in RUN; saturating.

## Operation
- FSM states: RUN, EXC_WAIT, REDIRECT. `busy` = (state != RUN).
- **RUN, no exc_flag.** Let k be the highest requesting stage: MEM=4, EX=3, ID=2, IF=1.
  - `stall[i]`=1 for all i < k.
  - `flush[k]`=1, inserting a bubble downstream of the stalled stage.
  - All other bits are 0.
  - Example, ex_stallreq alone: stall=5'b00111, flush=5'b01000.
  - With no request: stall=0, flush=0.
- **RUN, exc_flag=1.** This overrides all stall requests.
  - flush=5'b11110, stall=5'b00001.
  - Latch `exc_target` into `flush_pc`.
  - Next state is EXC_WAIT if `ibus_busy`=1, otherwise REDIRECT.
- **EXC_WAIT.**
  - flush=5'b11110, stall=5'b00001.
  - Stall requests and `exc_flag` are ignored.
  - Leave for REDIRECT in the first cycle where `ibus_busy`=0.
- **REDIRECT.**
  - `redirect`=1 for exactly this cycle.
  - flush=5'b11110, stall=0.
  - The PC loads `flush_pc` at the end of the cycle.
  - Next state is RUN unconditionally.
- **Counter.**
  - `stall_cnt` increments when state=RUN and `stall[0]`=1.
  - It saturates at all-ones.
  - `cnt_clr` has priority over increment.

## Timing
- `stall` and `flush` are combinational from the current inputs and state, with zero-cycle response.
- `redirect`, `flush_pc`, `busy`, `stall_cnt` and state are registered.
- **Reset values:**
  - state = RUN.
  - `flush_pc` = 32'h0.
  - `redirect` = 0.
  - `busy` = 0.
  - `stall_cnt` = 0.
  - While `rst`=1, `stall` = 0 and `flush` = 0.
- **Reset mid-operation:** `rst` asserted in EXC_WAIT or REDIRECT aborts the sequence immediately. No `redirect` pulse is emitted after reset.
- **Exception latency:**
  - exc_flag in cycle N with `ibus_busy`=0 gives `redirect` in N+1 and RUN in N+2.
  - With `ibus_busy`=1 through cycle N+m, `redirect` comes in N+m+2.
- `flush_pc` holds its value until the next accepted `exc_flag`.
- **Simultaneous events:**
  - exc_flag together with any stallreq: the exception wins and no stall pattern is produced.
  - Multiple stallreqs: the highest stage wins.
  - `cnt_clr` together with a counting cycle: the counter becomes 0.

## Test plan
- **Stall priority.** id_stallreq=1 and mem_stallreq=1 in RUN -> stall=5'b01111, flush=5'b10000, stall_cnt +1.
- **Single stalls.** if_stallreq only -> stall=5'b00001, flush=5'b00010. ex_stallreq only -> stall=5'b00111, flush=5'b01000.
- **Exception, bus idle.** exc_flag=1, exc_target=32'hBFC00380, ibus_busy=0, with ex_stallreq=1 -> flush=5'b11110 in N; redirect=1 with flush_pc=32'hBFC00380 in N+1; RUN with busy=0 in N+2.
- **Exception, bus busy.** ibus_busy high for 3 cycles after exc_flag -> EXC_WAIT for 3 cycles with flush=5'b11110 and stall=5'b00001; exactly one redirect pulse, in cycle N+4. A second exc_flag during EXC_WAIT leaves flush_pc unchanged.
- **Reset mid-sequence.** rst pulsed while in EXC_WAIT -> all outputs at reset values; no redirect pulse afterwards.
- **Counter.** stall_cnt preset to all-ones by continuous stalling with CNT_W=4 -> holds at 4'hF; cnt_clr with an active stall -> 0 the next cycle.
